// File: rtl/stream_decrypt_engine.sv
// Symbol-stream add/subtract cipher with a reloadable repeating key.
// One output register with pass-through backpressure; the key index restarts on every message end.
module stream_decrypt_engine #(
  parameter int unsigned p_data_width    = 8,
  parameter int unsigned p_secret_length = 6
) (
  input  logic                                    i_w_clk,
  input  logic                                    i_w_rst_n,
  input  logic [p_secret_length*p_data_width-1:0] i_w_secret,
  input  logic                                    i_w_load,
  input  logic                                    i_w_mode,
  input  logic                                    i_w_valid,
  input  logic [p_data_width-1:0]                 i_w_data,
  input  logic                                    i_w_last,
  output logic                                    o_r_ready,
  output logic                                    o_r_valid,
  output logic [p_data_width-1:0]                 o_r_data,
  output logic                                    o_r_last,
  input  logic                                    i_w_ready,
  output logic                                    o_r_keyed
);

  localparam int unsigned KeyW = p_secret_length * p_data_width;
  localparam int unsigned IdxW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(p_secret_length - 1);

  typedef enum logic {StNoKey, StRun} state_e;

  state_e                  r_state;
  logic [KeyW-1:0]         r_key;
  logic [IdxW-1:0]         r_idx;
  logic [p_data_width-1:0] w_key_sym;
  logic [p_data_width-1:0] w_result;
  logic                    w_in_xfer;
  logic                    w_out_xfer;

  // Symbol 0 lives in the MSBs of the key word.
  always_comb begin
    w_key_sym = '0;
    for (int i = 0; i < int'(p_secret_length); i++) begin
      if (r_idx == IdxW'(i)) begin
        w_key_sym = r_key[(int'(p_secret_length) - 1 - i)*int'(p_data_width) +: p_data_width];
      end
    end
  end

  assign w_result   = i_w_mode ? (i_w_data + w_key_sym) : (i_w_data - w_key_sym);
  assign o_r_ready  = (r_state == StRun) && !i_w_load && (!o_r_valid || i_w_ready);
  assign w_in_xfer  = i_w_valid && o_r_ready;
  assign w_out_xfer = o_r_valid && i_w_ready;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      r_state   <= StNoKey;
      r_key     <= '0;
      r_idx     <= '0;
      o_r_valid <= 1'b0;
      o_r_data  <= '0;
      o_r_last  <= 1'b0;
      o_r_keyed <= 1'b0;
    end else begin
      unique case (r_state)
        StNoKey: begin
          if (i_w_load) begin
            r_key     <= i_w_secret;
            r_idx     <= '0;
            o_r_keyed <= 1'b1;
            r_state   <= StRun;
          end
        end
        StRun: begin
          if (w_out_xfer) begin
            o_r_valid <= 1'b0;
          end
          // A simultaneous input transfer overrides the clear above.
          if (w_in_xfer) begin
            o_r_valid <= 1'b1;
            o_r_data  <= w_result;
            o_r_last  <= i_w_last;
            r_idx     <= (i_w_last || (r_idx == IdxMax)) ? '0 : r_idx + 1'b1;
          end
          // A pending result is left alone so it drains under the old key.
          if (i_w_load) begin
            r_key     <= i_w_secret;
            r_idx     <= '0;
            o_r_keyed <= 1'b1;
          end
        end
        default: r_state <= StNoKey;
      endcase
    end
  end

endmodule
